// File: rtl/alu_pkg.sv
// Shared decode constants, dispatch FSM states and the decoded-op record for the ALU front end.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;  // SUB / SRA / SRAI

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_WAIT_OPS = 2'd1,
    ST_VALID    = 2'd2
  } dispatch_state_e;

  typedef struct packed {
    logic        legal;
    logic        uses_imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm;
  } dec_op_t;

  // Field extraction only; rs2 is meaningless for OP-IMM but harmless to read.
  function automatic dec_op_t decode(input logic [31:0] instr);
    dec_op_t d;
    d.legal    = (instr[6:0] == OPC_OP) || (instr[6:0] == OPC_OP_IMM);
    d.uses_imm = (instr[6:0] == OPC_OP_IMM);
    d.rs1      = instr[19:15];
    d.rs2      = instr[24:20];
    d.rd       = instr[11:7];
    d.funct3   = instr[14:12];
    d.funct7   = instr[31:25];
    d.imm      = instr[31:20];
    return d;
  endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Pending-destination scoreboard for x1..x31; x0 is never pending.
// Latency: set/clear visible on the cycle after the edge; *_nxt ports show the post-edge value now.
// Backpressure: none; set wins over clear on the same register (the younger op owns it).
import alu_pkg::*;

module alu_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] ra1,
  input  logic [4:0] ra2,
  output logic       busy1,
  output logic       busy1_nxt,
  output logic       busy2,
  output logic       busy2_nxt
);

  logic [31:1] pend_q;
  logic [31:0] cur;
  logic [31:0] nxt;

  assign cur = {pend_q, 1'b0};

  // Apply clear first so a same-cycle set on the same register takes priority.
  always_comb begin
    nxt = cur;
    if (clr_en) nxt[clr_idx] = 1'b0;
    if (set_en) nxt[set_idx] = 1'b1;
    nxt[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= nxt[31:1];
  end

  assign busy1     = cur[ra1];
  assign busy1_nxt = nxt[ra1];
  assign busy2     = cur[ra2];
  assign busy2_nxt = nxt[ra2];

endmodule

// File: rtl/alu_dispatch.sv
// ALU dispatch: decodes OP/OP-IMM, reads the RF, waits on scoreboard hazards, presents registered operands.
// Latency: accept at cycle N -> out_valid at N+1 when no operand is pending.
// Backpressure: in_ready only when empty or issuing; outputs hold while out_valid & !out_ready.
// Build option WB_BYPASS_EN: pending operands capture wb_data directly instead of re-reading the RF.
import alu_pkg::*;

module alu_dispatch #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  output logic [4:0]            rf_raddr1,
  output logic [4:0]            rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] lhs,
  output logic [DATA_WIDTH-1:0] rhs,
  output logic                  lhs_valid,
  output logic                  rhs_valid,
  output logic                  uses_imm,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [4:0]            rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  illegal
);

  dispatch_state_e       state, state_nxt;
  dec_op_t               dec;
  logic [4:0]            rs1_q, rs2_q;
  logic                  accept, issue, load, illegal_nxt, sb_set;
  logic                  lhs_valid_nxt, rhs_valid_nxt;
  logic [DATA_WIDTH-1:0] lhs_nxt, rhs_nxt, imm_ext, dval1, dval2;
  logic                  busy1, busy1_nxt, busy2, busy2_nxt;
  logic                  hit1, hit2, pend1, pend2;

  assign dec     = decode(in_instr);
  assign imm_ext = {{(DATA_WIDTH-12){dec.imm[11]}}, dec.imm};

  assign out_valid = (state == ST_VALID);
  assign in_ready  = !rst && ((state == ST_EMPTY) || (out_valid && out_ready));
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready;
  assign sb_set    = issue && (rd != 5'd0);

  // While waiting, keep reading the held sources so a cleared bit can pick up the fresh RF value.
  assign rf_raddr1 = (state == ST_WAIT_OPS) ? rs1_q : dec.rs1;
  assign rf_raddr2 = (state == ST_WAIT_OPS) ? rs2_q : dec.rs2;

  assign hit1 = wb_valid && (wb_rd == rf_raddr1) && (rf_raddr1 != 5'd0);
  assign hit2 = wb_valid && (wb_rd == rf_raddr2) && (rf_raddr2 != 5'd0);

  alu_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (sb_set),
    .set_idx   (rd),
    .clr_en    (wb_valid),
    .clr_idx   (wb_rd),
    .ra1       (rf_raddr1),
    .ra2       (rf_raddr2),
    .busy1     (busy1),
    .busy1_nxt (busy1_nxt),
    .busy2     (busy2),
    .busy2_nxt (busy2_nxt)
  );

  // Decode-time operand resolution. Without bypass, a writeback landing this cycle still leaves the
  // RF read stale (RF is written on the same edge), so such an operand is treated as pending.
  always_comb begin
`ifdef WB_BYPASS_EN
    pend1 = busy1_nxt;
    pend2 = busy2_nxt;
    dval1 = hit1 ? wb_data : rf_rdata1;
    dval2 = hit2 ? wb_data : rf_rdata2;
`else
    pend1 = busy1_nxt || hit1;
    pend2 = busy2_nxt || hit2;
    dval1 = rf_rdata1;
    dval2 = rf_rdata2;
`endif
    if (dec.rs1 == 5'd0) begin
      pend1 = 1'b0;
      dval1 = '0;
    end
    if (dec.rs2 == 5'd0) begin
      pend2 = 1'b0;
      dval2 = '0;
    end
  end

  // Next-state and next-operand logic.
  always_comb begin
    state_nxt     = state;
    lhs_nxt       = lhs;
    rhs_nxt       = rhs;
    lhs_valid_nxt = lhs_valid;
    rhs_valid_nxt = rhs_valid;
    load          = 1'b0;
    illegal_nxt   = 1'b0;
    if (issue) begin
      state_nxt     = ST_EMPTY;
      lhs_valid_nxt = 1'b0;
      rhs_valid_nxt = 1'b0;
    end
    if (accept) begin
      if (!dec.legal) begin
        illegal_nxt = 1'b1;
        state_nxt   = ST_EMPTY;
      end else begin
        load          = 1'b1;
        lhs_nxt       = dval1;
        lhs_valid_nxt = !pend1;
        if (dec.uses_imm) begin
          rhs_nxt       = imm_ext;
          rhs_valid_nxt = 1'b1;
        end else begin
          rhs_nxt       = dval2;
          rhs_valid_nxt = !pend2;
        end
        state_nxt = (lhs_valid_nxt && rhs_valid_nxt) ? ST_VALID : ST_WAIT_OPS;
      end
    end else if (state == ST_WAIT_OPS) begin
      if (!lhs_valid) begin
`ifdef WB_BYPASS_EN
        if (hit1) begin
          lhs_nxt       = wb_data;
          lhs_valid_nxt = 1'b1;
        end else
`endif
        if (!busy1) begin
          lhs_nxt       = rf_rdata1;
          lhs_valid_nxt = 1'b1;
        end
      end
      if (!rhs_valid) begin
`ifdef WB_BYPASS_EN
        if (hit2) begin
          rhs_nxt       = wb_data;
          rhs_valid_nxt = 1'b1;
        end else
`endif
        if (!busy2) begin
          rhs_nxt       = rf_rdata2;
          rhs_valid_nxt = 1'b1;
        end
      end
      if (lhs_valid_nxt && rhs_valid_nxt) state_nxt = ST_VALID;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // Presented-op registers; decode fields only change when a legal op is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhs       <= '0;
      rhs       <= '0;
      lhs_valid <= 1'b0;
      rhs_valid <= 1'b0;
      uses_imm  <= 1'b0;
      funct3    <= '0;
      funct7    <= '0;
      rd        <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      illegal   <= 1'b0;
    end else begin
      lhs       <= lhs_nxt;
      rhs       <= rhs_nxt;
      lhs_valid <= lhs_valid_nxt;
      rhs_valid <= rhs_valid_nxt;
      illegal   <= illegal_nxt;
      if (load) begin
        uses_imm <= dec.uses_imm;
        funct3   <= dec.funct3;
        funct7   <= dec.funct7;
        rd       <= dec.rd;
        rs1_q    <= dec.rs1;
        rs2_q    <= dec.rs2;
      end
    end
  end

endmodule
